regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_wb_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/regfile_writeback.sv | 125 ++++++++++++
 tb/tb_regfile_writeback.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   REG_ADDR_W / REG_DATA_W : register index and value widths
//   wb_entry_t              : one buffered write {addr, data}
//   lk_result_t             : result of a pending-write lookup {hit, data}
//   LK_MISS                 : lookup result meaning "nothing pending"
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic                  hit;
    logic [REG_DATA_W-1:0] data;
  } lk_result_t;

  localparam lk_result_t LK_MISS = '{hit: 1'b0, data: '0};

endpackage

// File: rtl/wb_fifo.sv
// In-order entry store for the writeback buffer: storage, pointers, occupancy.
// Latency: a push is visible on head/entries/count the cycle after its edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pointers and count only)
//   push        : write push_entry at the tail on this edge
//   push_entry  : entry to store
//   pop         : retire the head entry on this edge
//   head        : oldest stored entry (meaningful only when count > 0)
//   entries     : raw storage, slot-indexed; rd_ptr/count say which slots are live
//   rd_ptr      : slot index of the head
//   count       : number of live entries, 0..DEPTH
import regfile_wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic [CNT_W-1:0]      count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: a slot is only ever read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  assign head    = mem[rd_ptr_q];
  assign entries = mem;
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback buffer in front of a single register-file write port, with pending-write lookup.
// Latency: a request accepted on edge N drives wr_ena from the cycle after edge N (registered only).
// Backpressure: req_ready drops when DEPTH entries are pending; wr_hold stalls the drain in place.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : writeback request handshake; req_addr/req_data carry the write
//   wr_hold               : register file port busy, do not issue this cycle
//   wr_ena/wr_addr/wr_data: register file write port (addr/data zero when idle)
//   lk_addr0/1            : register indices being read by the pipeline
//   lk_hit0/1             : that index has a write still sitting in the buffer
//   lk_data0/1            : youngest pending value for that index (0 on miss)
//   count                 : pending entries
//
// Build option: define REGFILE_WB_BYPASS_EN to forward pending data on lk_data0/1.
// Without it lk_data0/1 are held at 0 and lk_hit0/1 serve purely as stall flags.
import regfile_wb_pkg::*;

module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4:0]              req_addr,
  input  logic [31:0]             req_data,
  input  logic                    wr_hold,
  output logic                    wr_ena,
  output logic [4:0]              wr_addr,
  output logic [31:0]             wr_data,
  input  logic [4:0]              lk_addr0,
  input  logic [4:0]              lk_addr1,
  output logic                    lk_hit0,
  output logic                    lk_hit1,
  output logic [31:0]             lk_data0,
  output logic [31:0]             lk_data1,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t             push_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  push;
  logic                  pop;
  lk_result_t            res0;
  lk_result_t            res1;

  // Ready comes from the registered count only, so a pop while full does not
  // reopen the input until the following cycle.
  assign req_ready = !rst && (count_q < CNT_W'(DEPTH));

  // Writes to x0 complete the handshake but are never stored.
  assign push       = req_valid && req_ready && (req_addr != '0);
  assign push_entry = '{addr: req_addr, data: req_data};

  assign pop     = wr_ena;
  assign wr_ena  = !rst && (count_q != '0) && !wr_hold;
  assign wr_addr = wr_ena ? head.addr : '0;
  assign wr_data = wr_ena ? head.data : '0;
  assign count   = rst ? '0 : count_q;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (count_q)
  );

  // Scan live entries oldest to youngest so the last match wins, giving the
  // youngest value. Only registered state is searched: an entry being pushed
  // this cycle is not yet visible, and the head stays visible while it pops.
  function automatic lk_result_t lookup(
    input logic [REG_ADDR_W-1:0] addr,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [PTR_W-1:0]      base,
    input logic [CNT_W-1:0]      n
  );
    lk_result_t       r;
    logic [PTR_W-1:0] idx;
    r = LK_MISS;
    for (int i = 0; i < DEPTH; i++) begin
      idx = base + PTR_W'(i);
      if ((CNT_W'(i) < n) && (ents[idx].addr == addr)) begin
        r.hit  = 1'b1;
        r.data = ents[idx].data;
      end
    end
    // x0 is never pending.
    if (addr == '0) begin
      r = LK_MISS;
    end
    return r;
  endfunction

  assign res0 = rst ? LK_MISS : lookup(lk_addr0, entries, rd_ptr, count_q);
  assign res1 = rst ? LK_MISS : lookup(lk_addr1, entries, rd_ptr, count_q);

  assign lk_hit0 = res0.hit;
  assign lk_hit1 = res1.hit;

`ifdef REGFILE_WB_BYPASS_EN
  assign lk_data0 = res0.data;
  assign lk_data1 = res1.data;
`else
  // Forwarded values are not exposed in this build.
  logic lk_data_unused;
  assign lk_data_unused = ^{res0.data, res1.data};
  assign lk_data0 = '0;
  assign lk_data1 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH = 4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected lookup data depends on whether REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        wr_hold;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  lk_addr0;
  logic [4:0]  lk_addr1;
  logic        lk_hit0;
  logic        lk_hit1;
  logic [31:0] lk_data0;
  logic [31:0] lk_data1;
  logic [2:0]  count;

  int n_cmp;
  int n_bad;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_writeback #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_hold   (wr_hold),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lk_addr0  (lk_addr0),
    .lk_addr1  (lk_addr1),
    .lk_hit0   (lk_hit0),
    .lk_hit1   (lk_hit1),
    .lk_data0  (lk_data0),
    .lk_data1  (lk_data1),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    wr_hold   = 1'b0;
    lk_addr0  = '0;
    lk_addr1  = '0;

    // Reset state
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr_ena", 32'(wr_ena), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_hit0", 32'(lk_hit0), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_wr_addr", 32'(wr_addr), 32'd0);
    check("idle_wr_data", wr_data, 32'd0);

    // Single write: no combinational path, committed the next cycle
    req_valid = 1'b1; req_addr = 5'd5; req_data = 32'hDEADBEEF;
    #1;
    check("single_no_comb", 32'(wr_ena), 32'd0);
    tick();
    req_valid = 1'b0; lk_addr0 = 5'd5;
    #1;
    check("single_wr_ena", 32'(wr_ena), 32'd1);
    check("single_wr_addr", 32'(wr_addr), 32'd5);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    check("single_count", 32'(count), 32'd1);
    check("single_head_hit", 32'(lk_hit0), 32'd1);
    check("single_head_data", lk_data0, BYP ? 32'hDEADBEEF : 32'd0);
    tick();
    check("single_count_after", 32'(count), 32'd0);
    check("single_idle_ena", 32'(wr_ena), 32'd0);
    check("single_hit_after", 32'(lk_hit0), 32'd0);

    // x0 write is accepted but dropped
    req_valid = 1'b1; req_addr = 5'd0; req_data = 32'h1234;
    #1;
    check("x0_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    check("x0_count", 32'(count), 32'd0);
    check("x0_wr_ena", 32'(wr_ena), 32'd0);

    // Fill while the write port is held, then drain in order
    wr_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_addr  = 5'(k + 1);
      req_data  = 32'hA1 + 32'(k);
      tick();
    end
    req_valid = 1'b0; lk_addr0 = 5'd3; lk_addr1 = 5'd9;
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_held_ena", 32'(wr_ena), 32'd0);
    check("full_hit0", 32'(lk_hit0), 32'd1);
    check("full_data0", lk_data0, BYP ? 32'hA3 : 32'd0);
    check("full_miss1", 32'(lk_hit1), 32'd0);
    lk_addr0 = 5'd0;
    #1;
    check("full_x0_lookup", 32'(lk_hit0), 32'd0);
    req_valid = 1'b1; req_addr = 5'd9; req_data = 32'h99;
    tick();
    req_valid = 1'b0;
    #1;
    check("full_reject_count", 32'(count), 32'd4);
    check("full_reject_hit1", 32'(lk_hit1), 32'd0);
    wr_hold = 1'b0;
    #1;
    check("drain_ready_still_low", 32'(req_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("drain_wr_ena", 32'(wr_ena), 32'd1);
      check("drain_wr_addr", 32'(wr_addr), 32'(k + 1));
      check("drain_wr_data", wr_data, 32'hA1 + 32'(k));
      tick();
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_idle", 32'(wr_ena), 32'd0);

    // Simultaneous push and pop; a same-cycle push is not visible to lookup
    req_valid = 1'b1; req_addr = 5'd10; req_data = 32'h10;
    tick();
    req_addr = 5'd11; req_data = 32'h11; lk_addr1 = 5'd11;
    #1;
    check("pp_head_addr", 32'(wr_addr), 32'd10);
    check("pp_push_invisible", 32'(lk_hit1), 32'd0);
    tick();
    req_valid = 1'b0;
    #1;
    check("pp_count", 32'(count), 32'd1);
    check("pp_next_addr", 32'(wr_addr), 32'd11);
    check("pp_next_data", wr_data, 32'h11);
    check("pp_hit1", 32'(lk_hit1), 32'd1);
    tick();
    check("pp_empty", 32'(count), 32'd0);

    // Youngest matching entry wins
    wr_hold = 1'b1;
    req_valid = 1'b1; req_addr = 5'd7; req_data = 32'h11;
    tick();
    req_data = 32'h22;
    tick();
    req_valid = 1'b0; lk_addr0 = 5'd7; lk_addr1 = 5'd8;
    #1;
    check("young_hit0", 32'(lk_hit0), 32'd1);
    check("young_data0", lk_data0, BYP ? 32'h22 : 32'd0);
    check("young_miss1", 32'(lk_hit1), 32'd0);
    check("young_data1", lk_data1, 32'd0);
    req_valid = 1'b1; req_addr = 5'd8; req_data = 32'h33;
    tick();
    req_valid = 1'b0;
    #1;
    check("three_count", 32'(count), 32'd3);
    check("three_hit1", 32'(lk_hit1), 32'd1);
    check("three_data1", lk_data1, BYP ? 32'h33 : 32'd0);

    // Mid-operation reset discards everything
    rst = 1'b1; wr_hold = 1'b0;
    #1;
    check("inrst_count", 32'(count), 32'd0);
    check("inrst_wr_ena", 32'(wr_ena), 32'd0);
    check("inrst_ready", 32'(req_ready), 32'd0);
    check("inrst_hit0", 32'(lk_hit0), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("postrst_count", 32'(count), 32'd0);
    check("postrst_wr_ena", 32'(wr_ena), 32'd0);
    check("postrst_hit0", 32'(lk_hit0), 32'd0);
    check("postrst_hit1", 32'(lk_hit1), 32'd0);
    check("postrst_ready", 32'(req_ready), 32'd1);
    tick();
    check("postrst_still_idle", 32'(wr_ena), 32'd0);

    // Normal operation resumes after reset
    req_valid = 1'b1; req_addr = 5'd2; req_data = 32'h55;
    tick();
    req_valid = 1'b0;
    #1;
    check("resume_wr_addr", 32'(wr_addr), 32'd2);
    check("resume_wr_data", wr_data, 32'h55);
    tick();
    check("resume_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
